// File: rtl/stage1_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to
// instruction memory under a credit limit, queues in-order responses and
// hands {pc, instr, trap_if} to decode. Redirects flush the queue and
// discard in-flight responses; misaligned targets and bus errors become
// trap entries followed by a halt.
// Optional feature macro: FETCH_PERF_EN builds the perf_fetched /
// perf_stall counters; without it both ports read as zero.
module stage1_fetch #(
   parameter logic [47:0] RESET_PC = 48'h0,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        n_reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [47:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   input  logic        redirect_valid,
   input  logic [47:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [47:0] pc,
   output logic [31:0] instr,
   output logic        trap_if,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {RUN, TRAP_PEND, HALT} state_t;

   state_t      state, state_next;
   logic [47:0] fpc;          // next request address
   logic [47:0] kpc;          // address of the next response that will be kept
   logic [47:0] trap_pc;      // misaligned redirect target awaiting its trap entry
   logic [AW:0] outstanding;
   logic [AW:0] drop_cnt;
   logic [AW:0] wr_ptr, rd_ptr;
   logic [AW:0] occupancy, occ_eff, out_next;
   logic [AW+1:0] credit_sum;

   logic [47:0]      q_pc    [DEPTH];
   logic [31:0]      q_instr [DEPTH];
   logic [DEPTH-1:0] q_trap;

   logic        pop, req_fire, rsp_keep, rsp_err_keep;
   logic        push, push_trap;
   logic [47:0] push_pc;
   logic [31:0] push_instr;

   assign occupancy = wr_ptr - rd_ptr;
   assign dec_valid = (occupancy != '0);
   assign pop       = dec_valid && dec_ready;
   assign occ_eff   = occupancy - (AW+1)'(pop);
   assign credit_sum = {1'b0, occ_eff} + {1'b0, outstanding};

   // Requests only while running, never in a redirect cycle, and only while
   // every outstanding response is guaranteed a queue slot.
   assign imem_req_valid = n_reset && (state == RUN) && !redirect_valid &&
                           (credit_sum < (AW+2)'(DEPTH));
   assign imem_req_addr  = fpc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Any response arriving with a redirect belongs to the old stream.
   assign rsp_keep     = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
   assign rsp_err_keep = rsp_keep && imem_rsp_err && (state == RUN);
   assign out_next     = outstanding + (AW+1)'(req_fire) - (AW+1)'(imem_rsp_valid);

   // Next state and queue write selection.
   always_comb begin
      state_next = state;
      push       = 1'b0;
      push_pc    = kpc;
      push_instr = imem_rsp_data;
      push_trap  = 1'b0;
      if (redirect_valid) begin
         state_next = (redirect_pc[1:0] == 2'b00) ? RUN : TRAP_PEND;
      end else begin
         case (state)
            RUN: begin
               if (rsp_keep) begin
                  push = 1'b1;
                  if (imem_rsp_err) begin
                     push_instr = NOP;
                     push_trap  = 1'b1;
                     state_next = HALT;
                  end
               end
            end
            TRAP_PEND: begin
               if (occupancy == '0) begin
                  push       = 1'b1;
                  push_pc    = trap_pc;
                  push_instr = NOP;
                  push_trap  = 1'b1;
                  state_next = HALT;
               end
            end
            default: ;
         endcase
      end
   end

   // Control state: FSM, PCs, credit/drop counters and queue pointers.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state       <= RUN;
         fpc         <= RESET_PC;
         kpc         <= RESET_PC;
         trap_pc     <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         state       <= state_next;
         outstanding <= out_next;
         if (redirect_valid) begin
            // No request fires this cycle, so out_next is exactly the
            // in-flight count left after this cycle's response.
            drop_cnt <= out_next;
            rd_ptr   <= wr_ptr;
            if (redirect_pc[1:0] == 2'b00) begin
               fpc <= redirect_pc;
               kpc <= redirect_pc;
            end else begin
               trap_pc <= redirect_pc;
            end
         end else begin
            if (req_fire) fpc <= fpc + 48'd4;
            if (rsp_keep) kpc <= kpc + 48'd4;
            if (rsp_err_keep)
               drop_cnt <= out_next;
            else if (imem_rsp_valid && (drop_cnt != '0))
               drop_cnt <= drop_cnt - 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Queue storage; contents are only observed through valid entries.
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr[AW-1:0]]    <= push_pc;
         q_instr[wr_ptr[AW-1:0]] <= push_instr;
         q_trap[wr_ptr[AW-1:0]]  <= push_trap;
      end
   end

   assign pc      = dec_valid ? q_pc[rd_ptr[AW-1:0]]    : '0;
   assign instr   = dec_valid ? q_instr[rd_ptr[AW-1:0]] : '0;
   assign trap_if = dec_valid ? q_trap[rd_ptr[AW-1:0]]  : 1'b0;

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_cnt, stall_cnt;

   // Decode-side event counters, free-running and wrapping.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         fetched_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         if (pop)                    fetched_cnt <= fetched_cnt + 32'd1;
         if (dec_valid && !dec_ready) stall_cnt   <= stall_cnt + 32'd1;
      end
   end

   assign perf_fetched = fetched_cnt;
   assign perf_stall   = stall_cnt;
`else
   assign perf_fetched = '0;
   assign perf_stall   = '0;
`endif

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk) disable iff (!n_reset)
      !(push && !pop && (occupancy == (AW+1)'(DEPTH))));
`endif

endmodule

// File: tb/tb_stage1_fetch.sv
// Scenario bench for stage1_fetch: a latency-configurable in-order memory
// model, a decode-side scoreboard and one task per scenario.
module tb_stage1_fetch;

   logic        clk;
   logic        n_reset;
   logic        imem_req_valid, imem_req_ready;
   logic [47:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        redirect_valid;
   logic [47:0] redirect_pc;
   logic        dec_valid, dec_ready;
   logic [47:0] pc;
   logic [31:0] instr;
   logic        trap_if;
   logic [31:0] perf_fetched, perf_stall;

`ifdef FETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   stage1_fetch #(.RESET_PC(48'h1000), .DEPTH(4)) dut (
      .clk(clk), .n_reset(n_reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .imem_rsp_err(imem_rsp_err),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .pc(pc), .instr(instr), .trap_if(trap_if),
      .perf_fetched(perf_fetched), .perf_stall(perf_stall)
   );

   typedef struct {logic [47:0] pc; logic [31:0] instr; logic trap;} exp_t;
   typedef struct {logic [47:0] addr; int due;} mreq_t;

   exp_t  exp_q[$];
   mreq_t mq[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    pop_cnt  = 0;
   int    issued   = 0;
   int    cyc      = 0;
   int    mem_lat  = 1;
   logic        err_en   = 1'b0;
   logic [47:0] err_addr = '0;
   exp_t  mon_e;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_data(input logic [47:0] a);
      return a[31:0] ^ 32'hA5A5_0000;
   endfunction

   // In-order memory: a request accepted in cycle c answers in cycle c+mem_lat.
   initial begin
      mreq_t m;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      forever begin
         @(negedge clk);
         if (!n_reset) mq.delete();
         else if (imem_req_valid && imem_req_ready) begin
            m.addr = imem_req_addr;
            m.due  = cyc + mem_lat;
            mq.push_back(m);
            issued++;
         end
         @(posedge clk); #1;
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         imem_rsp_err   = 1'b0;
         if (n_reset && mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(m.addr);
            imem_rsp_err   = err_en && (m.addr == err_addr);
         end
      end
   end

   // Decode-side scoreboard: every accepted head is compared in order.
   always @(negedge clk) begin
      if (n_reset && dec_valid && dec_ready) begin
         n_checks++;
         pop_cnt++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected got pc=%h instr=%h trap=%b, required none", pc, instr, trap_if);
         end else begin
            mon_e = exp_q.pop_front();
            if ({pc, instr, trap_if} !== {mon_e.pc, mon_e.instr, mon_e.trap}) begin
               n_fail++;
               $display("FAIL sb_entry got pc=%h instr=%h trap=%b, required pc=%h instr=%h trap=%b",
                        pc, instr, trap_if, mon_e.pc, mon_e.instr, mon_e.trap);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_stream(input logic [47:0] base, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc    = base + 48'(4 * i);
         e.instr = mem_data(e.pc);
         e.trap  = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   // Leaves the bench at cycle 0: the first cycle with n_reset released.
   task automatic reset_and_start(input int lat);
      tick();
      n_reset = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      dec_ready = 1'b1;
      imem_req_ready = 1'b1;
      err_en = 1'b0;
      mem_lat = lat;
      repeat (3) tick();
      exp_q.delete();
      pop_cnt = 0;
      issued = 0;
      n_reset = 1'b1;
   endtask

   task automatic test_reset();
      reset_and_start(1);
      push_stream(48'h1000, 32);
      repeat (6) tick();
      n_reset = 1'b0;
      #1;
      n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got=%b required=0", imem_req_valid); end
      n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dec_valid got=%b required=0", dec_valid); end
      n_checks++; if (pc !== 48'h0) begin n_fail++; $display("FAIL rst_pc got=%h required=0", pc); end
      n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h required=0", instr); end
      n_checks++; if (trap_if !== 1'b0) begin n_fail++; $display("FAIL rst_trap got=%b required=0", trap_if); end
      n_checks++; if (perf_fetched !== 32'h0) begin n_fail++; $display("FAIL rst_perf_fetched got=%0d required=0", perf_fetched); end
      n_checks++; if (perf_stall !== 32'h0) begin n_fail++; $display("FAIL rst_perf_stall got=%0d required=0", perf_stall); end
      repeat (2) tick();
      exp_q.delete();
      push_stream(48'h1000, 4);
      n_reset = 1'b1;
      @(negedge clk);
      n_checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 48'h1000}) begin n_fail++; $display("FAIL rst_first_req got v=%b a=%h required v=1 a=1000", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_stream();
      reset_and_start(1);
      push_stream(48'h1000, 64);
      @(negedge clk);
      n_checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 48'h1000}) begin n_fail++; $display("FAIL stream_req0 got v=%b a=%h required v=1 a=1000", imem_req_valid, imem_req_addr); end
      n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL stream_dv0 got=%b required=0", dec_valid); end
      tick();
      @(negedge clk);
      n_checks++; if (imem_req_addr !== 48'h1004) begin n_fail++; $display("FAIL stream_req1 got=%h required=1004", imem_req_addr); end
      n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL stream_dv1 got=%b required=0", dec_valid); end
      tick();
      n_checks++; if ({dec_valid, pc} !== {1'b1, 48'h1000}) begin n_fail++; $display("FAIL stream_first_dec got v=%b pc=%h required v=1 pc=1000", dec_valid, pc); end
      repeat (18) tick();
      n_checks++; if (issued !== 20) begin n_fail++; $display("FAIL stream_issued got=%0d required=20", issued); end
      n_checks++; if (pop_cnt !== 18) begin n_fail++; $display("FAIL stream_pops got=%0d required=18", pop_cnt); end
   endtask

   task automatic test_stall();
      reset_and_start(1);
      push_stream(48'h1000, 64);
      repeat (6) tick();
      dec_ready = 1'b0;
      repeat (10) tick();
      n_checks++; if (issued - pop_cnt !== 4) begin n_fail++; $display("FAIL stall_inflight got=%0d required=4", issued - pop_cnt); end
      n_checks++; if (perf_stall !== (PERF ? 32'd10 : 32'd0)) begin n_fail++; $display("FAIL stall_perf_stall got=%0d required=%0d", perf_stall, PERF ? 10 : 0); end
      n_checks++; if (perf_fetched !== (PERF ? 32'(pop_cnt) : 32'd0)) begin n_fail++; $display("FAIL stall_perf_fetched got=%0d required=%0d", perf_fetched, PERF ? pop_cnt : 0); end
      dec_ready = 1'b1;
      repeat (12) tick();
      n_checks++; if (pop_cnt !== 16) begin n_fail++; $display("FAIL stall_resume_pops got=%0d required=16", pop_cnt); end
   endtask

   task automatic test_redirect();
      int p0;
      reset_and_start(3);
      push_stream(48'h1000, 64);
      repeat (10) tick();
      redirect_valid = 1'b1;
      redirect_pc = 48'h2000;
      @(negedge clk);
      n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_no_req got=%b required=0", imem_req_valid); end
      tick();
      redirect_valid = 1'b0;
      exp_q.delete();
      push_stream(48'h2000, 32);
      p0 = pop_cnt;
      n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got=%b required=0", dec_valid); end
      @(negedge clk);
      n_checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 48'h2000}) begin n_fail++; $display("FAIL redir_new_req got v=%b a=%h required v=1 a=2000", imem_req_valid, imem_req_addr); end
      repeat (4) tick();
      n_checks++; if ({dec_valid, pc} !== {1'b1, 48'h2000}) begin n_fail++; $display("FAIL redir_first_dec got v=%b pc=%h required v=1 pc=2000", dec_valid, pc); end
      repeat (10) tick();
      n_checks++; if (pop_cnt - p0 !== 10) begin n_fail++; $display("FAIL redir_pops got=%0d required=10", pop_cnt - p0); end
   endtask

   task automatic test_trap_redirect();
      int i0, p0;
      exp_t e;
      reset_and_start(1);
      push_stream(48'h1000, 64);
      repeat (5) tick();
      redirect_valid = 1'b1;
      redirect_pc = 48'h2002;
      @(negedge clk);
      n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL trap_no_req got=%b required=0", imem_req_valid); end
      tick();
      redirect_valid = 1'b0;
      exp_q.delete();
      e.pc = 48'h2002; e.instr = 32'h0000_0013; e.trap = 1'b1;
      exp_q.push_back(e);
      i0 = issued;
      p0 = pop_cnt;
      @(negedge clk);
      n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL trap_pend_req got=%b required=0", imem_req_valid); end
      tick();
      n_checks++; if ({dec_valid, pc, instr, trap_if} !== {1'b1, 48'h2002, 32'h13, 1'b1}) begin n_fail++; $display("FAIL trap_entry got v=%b pc=%h i=%h t=%b required v=1 pc=2002 i=13 t=1", dec_valid, pc, instr, trap_if); end
      repeat (8) tick();
      n_checks++; if (issued !== i0) begin n_fail++; $display("FAIL trap_halt_issued got=%0d required=%0d", issued, i0); end
      n_checks++; if (pop_cnt - p0 !== 1) begin n_fail++; $display("FAIL trap_halt_pops got=%0d required=1", pop_cnt - p0); end
      n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL trap_halt_dv got=%b required=0", dec_valid); end
      redirect_valid = 1'b1;
      redirect_pc = 48'h3000;
      push_stream(48'h3000, 32);
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      n_checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 48'h3000}) begin n_fail++; $display("FAIL trap_resume_req got v=%b a=%h required v=1 a=3000", imem_req_valid, imem_req_addr); end
      repeat (6) tick();
      n_checks++; if (pop_cnt - p0 !== 5) begin n_fail++; $display("FAIL trap_resume_pops got=%0d required=5", pop_cnt - p0); end
   endtask

   task automatic test_fetch_error();
      exp_t e;
      reset_and_start(2);
      err_en = 1'b1;
      err_addr = 48'h1008;
      push_stream(48'h1000, 2);
      e.pc = 48'h1008; e.instr = 32'h0000_0013; e.trap = 1'b1;
      exp_q.push_back(e);
      repeat (15) tick();
      // 0x1008 is requested in cycle 2 and answers in cycle 4; requests
      // keep flowing through cycle 4, so five are issued in all.
      n_checks++; if (issued !== 5) begin n_fail++; $display("FAIL err_issued got=%0d required=5", issued); end
      n_checks++; if (pop_cnt !== 3) begin n_fail++; $display("FAIL err_pops got=%0d required=3", pop_cnt); end
      n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL err_pending got=%0d required=0", exp_q.size()); end
      @(negedge clk);
      n_checks++; if ({imem_req_valid, dec_valid} !== 2'b00) begin n_fail++; $display("FAIL err_halt got req=%b dv=%b required 0 0", imem_req_valid, dec_valid); end
      err_en = 1'b0;
   endtask

   task automatic test_redirect_collide();
      int p0;
      reset_and_start(2);
      push_stream(48'h1000, 64);
      repeat (8) tick();
      redirect_valid = 1'b1;
      redirect_pc = 48'h2000;
      @(negedge clk);
      n_checks++; if ({dec_valid, imem_rsp_valid, imem_req_valid} !== 3'b110) begin n_fail++; $display("FAIL coll_cycle got dv=%b rsp=%b req=%b required 1 1 0", dec_valid, imem_rsp_valid, imem_req_valid); end
      tick();
      redirect_valid = 1'b0;
      exp_q.delete();
      push_stream(48'h2000, 32);
      p0 = pop_cnt;
      n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL coll_flush got=%b required=0", dec_valid); end
      repeat (3) tick();
      n_checks++; if ({dec_valid, pc} !== {1'b1, 48'h2000}) begin n_fail++; $display("FAIL coll_first_dec got v=%b pc=%h required v=1 pc=2000", dec_valid, pc); end
      repeat (6) tick();
      n_checks++; if (pop_cnt - p0 !== 6) begin n_fail++; $display("FAIL coll_pops got=%0d required=6", pop_cnt - p0); end
   endtask

   initial begin
      n_reset = 1'b0;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      dec_ready = 1'b1;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_trap_redirect();
      test_fetch_error();
      test_redirect_collide();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
